// File: rtl/alu_operand_stage_pkg.sv
// Shared CPU definitions: widths, ALU opcodes and the hard-wired zero register.
package alu_operand_stage_pkg;
  localparam int CPU_DATA_W = 32;
  localparam int CPU_REG_AW = 4;
  localparam int CPU_OPC_W  = 4;
  localparam int R0         = 0;

  localparam logic [CPU_OPC_W-1:0] OPC_OR     = 4'd0;
  localparam logic [CPU_OPC_W-1:0] OPC_AND    = 4'd1;
  localparam logic [CPU_OPC_W-1:0] OPC_XOR    = 4'd2;
  localparam logic [CPU_OPC_W-1:0] OPC_ADD    = 4'd3;
  localparam logic [CPU_OPC_W-1:0] OPC_SUB    = 4'd4;
  localparam logic [CPU_OPC_W-1:0] OPC_SLL    = 4'd5;
  localparam logic [CPU_OPC_W-1:0] OPC_SRL    = 4'd6;
  localparam logic [CPU_OPC_W-1:0] OPC_SRA    = 4'd7;
  localparam logic [CPU_OPC_W-1:0] OPC_SLT    = 4'd8;
  localparam logic [CPU_OPC_W-1:0] OPC_SLTU   = 4'd9;
  localparam logic [CPU_OPC_W-1:0] OPC_LOADHI = 4'd10;
endpackage

// File: rtl/alu_operand_stage_operand_forward_mux.sv
// Per-source operand resolution: r0 -> 0, then MEM (non-load), then WB, then held data.
module operand_forward_mux
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW
) (
  input  logic [REG_AW-1:0] i_src,
  input  logic [DATA_W-1:0] i_held_data,
  input  logic              i_mem_we,
  input  logic              i_mem_is_load,
  input  logic [REG_AW-1:0] i_mem_rd,
  input  logic [DATA_W-1:0] i_mem_data,
  input  logic              i_wb_we,
  input  logic [REG_AW-1:0] i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_operand
);
  // A load in MEM has no data yet; the stage stalls on it instead of forwarding.
  always_comb begin
    o_operand = i_held_data;
    if (i_src == REG_AW'(R0))                                     o_operand = '0;
    else if (i_mem_we && !i_mem_is_load && (i_mem_rd == i_src))   o_operand = i_mem_data;
    else if (i_wb_we && (i_wb_rd == i_src))                       o_operand = i_wb_data;
  end
endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX register in front of the ALU: captures decode, forwards from MEM/WB,
// inserts bubbles on load-use hazards, valid/ready on both sides.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int REG_AW = CPU_REG_AW,
  parameter int OPC_W  = CPU_OPC_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_we,
  input  logic              mem_we,
  input  logic              mem_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OPC_W-1:0]  alu_opcode,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_we,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  stall_count
);
  logic              r_valid;
  logic [OPC_W-1:0]  r_opcode;
  logic [REG_AW-1:0] r_rs1, r_rs2, r_rd;
  logic [DATA_W-1:0] r_rs1_data, r_rs2_data, r_imm;
  logic              r_use_imm, r_we;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic                   w_fire_in, w_fire_out, w_hazard;
  logic [1:0][REG_AW-1:0] w_src;
  logic [1:0][DATA_W-1:0] w_held, w_fwd;

  assign w_src  = {r_rs2, r_rs1};
  assign w_held = {r_rs2_data, r_rs1_data};

  // One resolver per source operand (0 = rs1, 1 = rs2)
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    operand_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_mux (
      .i_src(w_src[g]), .i_held_data(w_held[g]),
      .i_mem_we(mem_we), .i_mem_is_load(mem_is_load), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
      .i_wb_we(wb_we), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
      .o_operand(w_fwd[g])
    );
  end

  assign w_hazard = r_valid && mem_we && mem_is_load && (mem_rd != REG_AW'(R0)) &&
                    ((mem_rd == r_rs1) || (!r_use_imm && (mem_rd == r_rs2)));

  assign out_valid    = r_valid && !w_hazard;
  assign w_fire_out   = out_valid && out_ready;
  assign in_ready     = !r_valid || w_fire_out;
  assign w_fire_in    = in_valid && in_ready;
  assign hazard_stall = w_hazard;
  assign alu_a        = w_fwd[0];
  assign alu_b        = r_use_imm ? r_imm : w_fwd[1];
  assign alu_opcode   = r_opcode;
  assign out_rd       = r_rd;
  assign out_we       = r_we && out_valid;
  assign stall_count  = r_stall_cnt;

  // Holding register: flush beats capture, capture beats drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid    <= 1'b0;
      r_opcode   <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_use_imm  <= 1'b0;
      r_rd       <= '0;
      r_we       <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_fire_in) begin
      r_valid    <= 1'b1;
      r_opcode   <= in_opcode;
      r_rs1      <= in_rs1;
      r_rs2      <= in_rs2;
      r_rs1_data <= in_rs1_data;
      r_rs2_data <= in_rs2_data;
      r_imm      <= in_imm;
      r_use_imm  <= in_use_imm;
      r_rd       <= in_rd;
      r_we       <= in_we;
    end else if (w_fire_out) begin
      r_valid <= 1'b0;
    end
  end

  // Saturating count of bubble cycles; survives flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             r_stall_cnt <= '0;
    else if (w_hazard && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage with an in-order scoreboard of ALU-side results.
module tb_alu_operand_stage;
  logic        clk = 1'b0, reset = 1'b0, flush = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [3:0]  in_opcode = '0, in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0;
  logic        in_use_imm = 1'b0, in_we = 1'b0;
  logic        mem_we = 1'b0, mem_is_load = 1'b0, wb_we = 1'b0;
  logic [3:0]  mem_rd = '0, wb_rd = '0;
  logic [31:0] mem_data = '0, wb_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_opcode, out_rd;
  logic        out_we, hazard_stall;
  logic [15:0] stall_count;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  opc;
    logic [3:0]  rd;
    logic        we;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0, n_fail = 0, n_fires = 0;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd), .in_we(in_we),
    .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .out_rd(out_rd), .out_we(out_we),
    .hazard_stall(hazard_stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Settle, score any ALU-side fire, then advance one clock.
  task automatic step();
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      n_fires++;
      if (sb.size() == 0) chk("unexpected_fire", 64'(alu_a), 64'hdead_0000_0000);
      else begin
        e = sb.pop_front();
        chk("sb_a", 64'(alu_a), 64'(e.a));
        chk("sb_b", 64'(alu_b), 64'(e.b));
        chk("sb_opc", 64'(alu_opcode), 64'(e.opc));
        chk("sb_rd", 64'(out_rd), 64'(e.rd));
        chk("sb_we", 64'(out_we), 64'(e.we));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] opc, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic use_imm, input logic [3:0] rd, input logic we);
    in_valid = 1'b1; in_opcode = opc; in_rs1 = rs1; in_rs2 = rs2;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm; in_use_imm = use_imm;
    in_rd = rd; in_we = we;
  endtask

  function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic [3:0] opc,
                              input logic [3:0] rd, input logic we);
    exp_t e;
    e.a = a; e.b = b; e.opc = opc; e.rd = rd; e.we = we;
    return e;
  endfunction

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    chk("rst_hazard", 64'(hazard_stall), 64'd0);
    chk("rst_count", 64'(stall_count), 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    // Mid-stream async reset drops a held instruction
    issue(4'd4, 4'd1, 4'd2, 32'h1, 32'h2, 32'h0, 1'b0, 4'd5, 1'b1);
    step();
    in_valid = 1'b0;
    #1 chk("held_before_rst", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1 chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_we", 64'(out_we), 64'd0);
    chk("async_rst_opc", 64'(alu_opcode), 64'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Basic ADD pass-through, one cycle latency
    out_ready = 1'b1;
    issue(4'd3, 4'd1, 4'd2, 32'd5, 32'd7, 32'h0, 1'b0, 4'd9, 1'b1);
    sb.push_back(mk(32'd5, 32'd7, 4'd3, 4'd9, 1'b1));
    step();
    in_valid = 1'b0;
    #1 chk("add_valid", 64'(out_valid), 64'd1);
    chk("add_opcode", 64'(alu_opcode), 64'h3);
    step();

    // MEM has priority over WB; WB used once MEM drops
    out_ready = 1'b0;
    issue(4'd1, 4'd3, 4'd5, 32'h1, 32'h9, 32'h0, 1'b0, 4'd6, 1'b1);
    step();
    in_valid = 1'b0;
    mem_we = 1'b1; mem_rd = 4'd3; mem_data = 32'hAAAA0000;
    wb_we = 1'b1; wb_rd = 4'd3; wb_data = 32'h11;
    #1 chk("fwd_mem_prio", 64'(alu_a), 64'hAAAA0000);
    mem_we = 1'b0;
    #1 chk("fwd_wb", 64'(alu_a), 64'h11);
    out_ready = 1'b1;
    sb.push_back(mk(32'h11, 32'h9, 4'd1, 4'd6, 1'b1));
    step();
    wb_we = 1'b0;

    // r0 reads zero; immediate masks rs2 and its load hazard
    out_ready = 1'b0;
    issue(4'd10, 4'd0, 4'd6, 32'h77, 32'h55, 32'h1234, 1'b1, 4'd2, 1'b0);
    step();
    in_valid = 1'b0;
    mem_we = 1'b1; mem_rd = 4'd0; mem_data = 32'hFFFF;
    #1 chk("r0_zero", 64'(alu_a), 64'd0);
    mem_rd = 4'd6; mem_is_load = 1'b1;
    #1 chk("imm_b", 64'(alu_b), 64'h1234);
    chk("imm_no_stall", 64'(hazard_stall), 64'd0);
    out_ready = 1'b1;
    sb.push_back(mk(32'h0, 32'h1234, 4'd10, 4'd2, 1'b0));
    step();
    mem_we = 1'b0; mem_is_load = 1'b0;

    // Load-use on rs2: one bubble, then resolves through WB
    issue(4'd4, 4'd1, 4'd4, 32'h3, 32'h50, 32'h0, 1'b0, 4'd7, 1'b1);
    sb.push_back(mk(32'h3, 32'hDEAD, 4'd4, 4'd7, 1'b1));
    step();
    in_valid = 1'b0;
    mem_we = 1'b1; mem_is_load = 1'b1; mem_rd = 4'd4;
    #1 chk("lu_stall", 64'(hazard_stall), 64'd1);
    chk("lu_out_valid", 64'(out_valid), 64'd0);
    chk("lu_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("lu_count", 64'(stall_count), 64'd1);
    mem_we = 1'b0; mem_is_load = 1'b0;
    wb_we = 1'b1; wb_rd = 4'd4; wb_data = 32'hDEAD;
    #1 chk("lu_resolved", 64'(out_valid), 64'd1);
    step();
    wb_we = 1'b0;

    // Backpressure then back-to-back streaming
    out_ready = 1'b0;
    issue(4'd2, 4'd1, 4'd2, 32'h10, 32'h20, 32'h0, 1'b0, 4'd1, 1'b1);
    sb.push_back(mk(32'h10, 32'h20, 4'd2, 4'd1, 1'b1));
    step();
    issue(4'd5, 4'd1, 4'd2, 32'h11, 32'h21, 32'h0, 1'b0, 4'd2, 1'b1);
    sb.push_back(mk(32'h11, 32'h21, 4'd5, 4'd2, 1'b1));
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_stable", {alu_a, alu_b}, {32'h10, 32'h20});
      step();
    end
    out_ready = 1'b1;
    n_fires = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      issue(4'd6 + 4'(i), 4'd1, 4'd2, 32'h12 + i, 32'h22 + i, 32'h0, 1'b0, 4'd3 + 4'(i), 1'b1);
      sb.push_back(mk(32'h12 + i, 32'h22 + i, 4'd6 + 4'(i), 4'd3 + 4'(i), 1'b1));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("stream_fires", 64'(n_fires), 64'd5);
    chk("stream_drained", 64'(sb.size()), 64'd0);

    // Flush wins over simultaneous capture
    issue(4'd7, 4'd1, 4'd2, 32'hBAD, 32'hBAD, 32'h0, 1'b0, 4'd8, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    #1 chk("flush_drop", 64'(out_valid), 64'd0);
    step();

    // Counter saturation, unaffected by flush
    out_ready = 1'b1;
    issue(4'd3, 4'd7, 4'd0, 32'h44, 32'h0, 32'h0, 1'b0, 4'd1, 1'b1);
    step();
    in_valid = 1'b0;
    mem_we = 1'b1; mem_is_load = 1'b1; mem_rd = 4'd7;
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1 chk("sat_count", 64'(stall_count), 64'hFFFF);
    mem_we = 1'b0; mem_is_load = 1'b0;
    sb.push_back(mk(32'h44, 32'h0, 4'd3, 4'd1, 1'b1));
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_keeps_count", 64'(stall_count), 64'hFFFF);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
